instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage upstream of the main control decoder.
//  - Holds the PC and requests instruction words from instruction memory over a req/ack handshake.
//  - Presents the fetched word, its 6-bit opcode and the PC to decode/execute over a valid/ready handshake.
//  - Computes the next PC: sequential, beq target, or jump target.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   synchronous active-low reset
//  imem_req       out  1   instruction memory read request
//  imem_addr      out  32  byte address of the request (equals pc)
//  imem_ack       in   1   imem_rdata is valid this cycle
//  imem_rdata     in   32  instruction word from memory
//  instr          out  32  registered instruction word
//  opcode         out  6   instr[31:26], feeds the main control decoder
//  instr_valid    out  1   instr/opcode/pc are valid
//  instr_ready    in   1   consumer accepts the instruction this cycle
//  branch_taken   in   1   beq resolved taken (branch & zero); sampled only on accept
//  branch_offset  in   32  sign-extended immediate, in words
//  pc             out  32  address of the current instruction
//  pc_plus4       out  32  pc + 4 (mod 2^32)
//  jump           in   1   [JUMP_EN only] j resolved; sampled only on accept
//  jump_target    in   26  [JUMP_EN only] instr[25:0] of the j
// BEHAVIOUR
//  States: IDLE, FETCH, VALID.
//  - Reset (rst_n low at a clock edge): state=IDLE, pc=PC_RESET, instr=0, instr_valid=0.
//    imem_req=0 while in IDLE.
//  - IDLE -> FETCH unconditionally on the next edge.
//  - FETCH: imem_req=1, imem_addr=pc held stable until ack.
//    On imem_ack: instr<=imem_rdata, go to VALID.
//  - VALID: instr_valid=1, imem_req=0. instr/pc stay stable while instr_ready=0.
//    On instr_ready: pc<=next_pc, go to FETCH.
//  - Outputs: imem_req=(state==FETCH); instr_valid=(state==VALID); opcode=instr[31:26].
//  - imem_ack is ignored outside FETCH. A late ack after reset or in IDLE/VALID has no effect.
//  - next_pc priority (mod 2^32 wrap, bits [1:0] forced 0):
//    1. jump (JUMP_EN): {pc_plus4[31:28], jump_target, 2'b00}
//    2. branch_taken: pc_plus4 + (branch_offset << 2)
//    3. otherwise: pc_plus4
//  - jump and branch_taken are both high -> jump wins.
//  - Latency: imem_addr appears the first cycle in FETCH. instr_valid rises the cycle after ack.
//    Minimum 2 cycles per instruction with ack and ready each held high.
//  - Reset mid-operation: state/pc return to reset values at the edge.
//    An outstanding request is abandoned (req drops).
//  - pc=32'hFFFF_FFFC, sequential -> next pc = 0.
// CONFIGURATION
//  JUMP_EN defined:
//    - jump/jump_target ports exist.
//    - The j opcode (6'b000010) path is in next_pc.
//  JUMP_EN undefined:
//    - Those ports are absent.
//    - next_pc is branch or sequential only.
// STRUCTURE
//  fetch_pkg holds:
//    - the state enum (IDLE/FETCH/VALID)
//    - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010
//    - the PC_STEP=4 constant
//  Sub-module pc_next: combinational next-PC adder and priority mux.
//  instr_fetch keeps the FSM, the PC register and the instruction register.
// TESTING
//  1. Reset release, ack tied high:
//     imem_addr=0, then 4, 8. instr_valid pulses with opcode=imem_rdata[31:26] each time.
//  2. ack delayed 3 cycles:
//     imem_req and imem_addr stay stable throughout. instr_valid=0 until the cycle after ack.
//  3. instr_ready low for 5 cycles in VALID:
//     instr and pc stay constant, imem_req=0. Fetch resumes at pc+4 after accept.
//  4. Branch at pc=0x08, offset=3, taken -> next imem_addr=0x18.
//     Branch at pc=0x10, offset=-1 -> next imem_addr=0x10.
//  5. rst_n low during FETCH with ack arriving the next cycle:
//     imem_req=0, pc=PC_RESET, and the ack is ignored.
//     PC_RESET=32'hFFFF_FFFC with a sequential accept -> next pc=0.
//  6. JUMP_EN at pc=0x1000_0004, jump_target=26'h40, branch_taken=1 also asserted
//     -> next imem_addr=0x1000_0100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, opcode constants and PC step for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: next-PC adder and priority mux (jump over branch over sequential); jump path under JUMP_EN
module pc_next
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
`ifdef JUMP_EN
    input  logic        jump,
    input  logic [25:0] jump_target,
`endif
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);
    logic [31:0] branch_target;
    logic [31:0] raw_pc;
    assign pc_plus4 = pc + PC_STEP;
    assign branch_target = pc_plus4 + (branch_offset << 2);
    // Pick the highest-priority redirect, then keep the result word aligned
    always_comb begin
`ifdef JUMP_EN
        raw_pc = jump ? {pc_plus4[31:28], jump_target, 2'b00} : branch_taken ? branch_target : pc_plus4;
`else
        raw_pc = branch_taken ? branch_target : pc_plus4;
`endif
        next_pc = {raw_pc[31:2], 2'b00};
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, imem req/ack fetch FSM and instruction register; JUMP_EN adds the j path
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
`ifdef JUMP_EN
    input  logic        jump,
    input  logic [25:0] jump_target,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    state_t state, state_d;
    logic [31:0] next_pc;

    pc_next u_pc_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
`ifdef JUMP_EN
        .jump          (jump),
        .jump_target   (jump_target),
`endif
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    assign instr_valid = state == VALID;
    assign opcode = instr[31:26];

    // Advance IDLE -> FETCH, FETCH -> VALID on ack, VALID -> FETCH on accept
    always_comb begin
        state_d = state;
        if (state == IDLE) state_d = FETCH;
        else if (state == FETCH && imem_ack) state_d = VALID;
        else if (state == VALID && instr_ready) state_d = FETCH;
    end

    // State, instruction capture on ack and PC update on accept; reset abandons any request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= PC_RESET;
            instr <= '0;
        end else begin
            state <= state_d;
            if (state == FETCH && imem_ack) instr <= imem_rdata;
            if (state == VALID && instr_ready) pc <= next_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch; define JUMP_EN to cover the jump path
module tb_instr_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode;
    logic        imem_ack = 0, instr_ready = 0, branch_taken = 0;
    logic [31:0] imem_rdata = 0, branch_offset = 0;
`ifdef JUMP_EN
    logic        jump = 0;
    logic [25:0] jump_target = 0;
`endif
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc2, pc_plus4_2;
    logic [5:0]  opcode2;
    logic        one = 1'b1, zero = 1'b0;
    logic [31:0] rdata2 = 32'h0800_0000, zero32 = 32'd0;
    int errors = 0, checks = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk (clk), .rst_n (rst_n), .imem_req (imem_req), .imem_addr (imem_addr),
        .imem_ack (imem_ack), .imem_rdata (imem_rdata), .instr (instr), .opcode (opcode),
        .instr_valid (instr_valid), .instr_ready (instr_ready), .branch_taken (branch_taken),
        .branch_offset (branch_offset),
`ifdef JUMP_EN
        .jump (jump), .jump_target (jump_target),
`endif
        .pc (pc), .pc_plus4 (pc_plus4)
    );

    instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
        .clk (clk), .rst_n (rst_n), .imem_req (req2), .imem_addr (addr2),
        .imem_ack (one), .imem_rdata (rdata2), .instr (instr2), .opcode (opcode2),
        .instr_valid (valid2), .instr_ready (one), .branch_taken (zero),
        .branch_offset (zero32),
`ifdef JUMP_EN
        .jump (zero), .jump_target (26'd0),
`endif
        .pc (pc2), .pc_plus4 (pc_plus4_2)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[7:2] ^ 6'h2b, a[27:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input logic [31:0] a);
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, a);
        chk("valid_low", {31'd0, instr_valid}, 32'd0);
    endtask

    // Observe at the current negedge (scoreboard pop on accept), drive inputs, advance one cycle
    task automatic step(input logic ack, input logic rdy);
        logic [63:0] e;
        if (instr_valid && rdy) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty observed=%0d expected=1", exp_q.size());
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("instr", instr, e[63:32]);
                chk("opcode", {26'd0, opcode}, {26'd0, e[63:58]});
                chk("pc", pc, e[31:0]);
                chk("pc_plus4", pc_plus4, e[31:0] + 32'd4);
                chk("req_in_valid", {31'd0, imem_req}, 32'd0);
            end
        end
        imem_ack = ack;
        instr_ready = rdy;
        imem_rdata = word(imem_addr);
        if (ack && imem_req) exp_q.push_back({word(imem_addr), imem_addr});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        imem_ack = 0;
        instr_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc2", pc2, 32'hFFFF_FFFC);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        // Reset, then back-to-back fetches with ack and ready held high
        do_reset();
        chk("u2_addr", addr2, 32'hFFFF_FFFC);
        chk("u2_req", {31'd0, req2}, 32'd1);
        chk_fetch(32'h0);
        step(1, 1);
        chk("u2_valid", {31'd0, valid2}, 32'd1);
        chk("u2_pc_plus4", pc_plus4_2, 32'h0);
        step(1, 1);
        chk("u2_wrap_addr", addr2, 32'h0);
        chk("u2_wrap_req", {31'd0, req2}, 32'd1);
        for (int i = 1; i < 3; i++) begin
            chk_fetch(32'(i * 4));
            step(1, 1);
            step(1, 1);
        end
        // Ack delayed three cycles: request held stable, no valid until after ack
        for (int i = 0; i < 3; i++) begin
            chk_fetch(32'h0C);
            step(0, 1);
        end
        chk_fetch(32'h0C);
        step(1, 1);
        step(1, 1);
        // Consumer stalls five cycles: instruction and pc hold, no request
        chk_fetch(32'h10);
        step(1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_instr", instr, word(32'h10));
            chk("stall_pc", pc, 32'h10);
            step(0, 0);
        end
        step(0, 1);
        chk_fetch(32'h14);
        // Branches: 0x08 +3 -> 0x18, 0x18 -3 -> 0x10, 0x10 -1 -> 0x10
        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk_fetch(32'(i * 4));
            step(1, 1);
            step(1, 1);
        end
        chk_fetch(32'h08);
        step(1, 1);
        branch_taken = 1;
        branch_offset = 32'd3;
        step(1, 1);
        branch_taken = 0;
        chk_fetch(32'h18);
        step(1, 1);
        branch_taken = 1;
        branch_offset = -32'sd3;
        step(1, 1);
        branch_taken = 0;
        chk_fetch(32'h10);
        step(1, 1);
        branch_taken = 1;
        branch_offset = -32'sd1;
        step(1, 1);
        branch_taken = 0;
        chk_fetch(32'h10);
        // Reset during FETCH with a late ack arriving while in IDLE
        step(0, 0);
        rst_n = 0;
        imem_ack = 0;
        @(negedge clk);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        rst_n = 1;
        imem_ack = 1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 0;
        chk_fetch(32'h0);
        chk("late_ack_instr", instr, 32'd0);
`ifdef JUMP_EN
        // Jump beats a simultaneous taken branch
        step(1, 1);
        branch_taken = 1;
        branch_offset = 32'h0400_0000;
        step(1, 1);
        chk_fetch(32'h1000_0004);
        step(1, 1);
        jump = 1;
        jump_target = 26'h40;
        step(1, 1);
        jump = 0;
        branch_taken = 0;
        chk_fetch(32'h1000_0100);
`else
        step(1, 1);
        step(1, 1);
        chk_fetch(32'h4);
`endif
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
